// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage with IF/ID and ID/EX registers
//
// Latches the fetched instruction, decodes it, reads the 8x8 register file
// and presents a registered ID/EX bundle to execute. It also owns the register
// file write port, load-use hazard detection and branch flush.
//
// Ports:
//   clk, reset            clock; asynchronous active-high reset
//   if_pc, if_instr       PC and 16-bit instruction at fetch output
//   flush                 taken branch from execute; kills IF/ID and ID/EX
//   wb_en, wb_addr,
//   wb_data               register-file write port (bypassed to reads)
//   stall                 combinational; fetch holds PC and instruction
//   ex_valid .. ex_illegal  registered ID/EX bundle

module id_stage (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  if_pc,
  input  logic [15:0] if_instr,
  input  logic        flush,
  input  logic        wb_en,
  input  logic [2:0]  wb_addr,
  input  logic [7:0]  wb_data,
  output logic        stall,
  output logic        ex_valid,
  output logic [7:0]  ex_pc,
  output logic [7:0]  ex_rs1_val,
  output logic [7:0]  ex_rs2_val,
  output logic [7:0]  ex_imm,
  output logic [2:0]  ex_rd,
  output logic [2:0]  ex_alu_op,
  output logic        ex_reg_write,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_branch,
  output logic        ex_use_imm,
  output logic        ex_illegal
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_ADDI = 4'd5;
  localparam logic [3:0] OP_LD   = 4'd6;
  localparam logic [3:0] OP_ST   = 4'd7;
  localparam logic [3:0] OP_BEQ  = 4'd8;

  // ALU code 4 (PASS-B) is part of the execute encoding but no opcode selects it.
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;

  typedef struct packed {
    logic       valid;
    logic [7:0] pc;
    logic [7:0] rs1_val;
    logic [7:0] rs2_val;
    logic [7:0] imm;
    logic [2:0] rd;
    logic [2:0] alu_op;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       use_imm;
    logic       illegal;
  } idex_t;

  // IF/ID pipeline register
  logic        ifid_valid;
  logic [7:0]  ifid_pc;
  logic [15:0] ifid_instr;

  // ID/EX pipeline register
  idex_t idex_q;
  idex_t idex_d;

  // Register file; entry 0 is never written and reads are forced to 0
  logic [7:0] regs [8];

  // Decoded fields
  logic [3:0] f_op;
  logic [2:0] f_rd;
  logic [2:0] f_rs1;
  logic [2:0] f_rs2;
  logic [7:0] f_imm;
  logic [7:0] rs1_val;
  logic [7:0] rs2_val;

  // Decoded control
  logic       c_reg_write;
  logic       c_mem_read;
  logic       c_mem_write;
  logic       c_branch;
  logic       c_use_imm;
  logic       c_illegal;
  logic [2:0] c_alu_op;
  logic       uses_rs1;
  logic       uses_rs2;

  logic       load_pending;

  assign f_op  = ifid_instr[15:12];
  assign f_rd  = ifid_instr[11:9];
  assign f_rs1 = ifid_instr[8:6];
  // ST carries its store-data register and BEQ its second compare register in [11:9]
  assign f_rs2 = (f_op == OP_ST || f_op == OP_BEQ) ? ifid_instr[11:9] : ifid_instr[5:3];
  assign f_imm = {{2{ifid_instr[5]}}, ifid_instr[5:0]};

  // Read ports with same-cycle bypass from the write port
  assign rs1_val = (f_rs1 == 3'd0) ? 8'd0 :
                   (wb_en && wb_addr == f_rs1) ? wb_data : regs[f_rs1];
  assign rs2_val = (f_rs2 == 3'd0) ? 8'd0 :
                   (wb_en && wb_addr == f_rs2) ? wb_data : regs[f_rs2];

  always_comb begin
    c_reg_write = 1'b0;
    c_mem_read  = 1'b0;
    c_mem_write = 1'b0;
    c_branch    = 1'b0;
    c_use_imm   = 1'b0;
    c_illegal   = 1'b0;
    c_alu_op    = ALU_ADD;
    uses_rs1    = 1'b0;
    uses_rs2    = 1'b0;
    case (f_op)
      OP_NOP: ;
      OP_ADD: begin
        c_reg_write = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_SUB: begin
        c_reg_write = 1'b1;
        c_alu_op    = ALU_SUB;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_AND: begin
        c_reg_write = 1'b1;
        c_alu_op    = ALU_AND;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_OR: begin
        c_reg_write = 1'b1;
        c_alu_op    = ALU_OR;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_ADDI: begin
        c_reg_write = 1'b1;
        c_use_imm   = 1'b1;
        uses_rs1    = 1'b1;
      end
      OP_LD: begin
        c_reg_write = 1'b1;
        c_use_imm   = 1'b1;
        c_mem_read  = 1'b1;
        uses_rs1    = 1'b1;
      end
      OP_ST: begin
        c_use_imm   = 1'b1;
        c_mem_write = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      OP_BEQ: begin
        c_alu_op    = ALU_SUB;
        c_branch    = 1'b1;
        uses_rs1    = 1'b1;
        uses_rs2    = 1'b1;
      end
      default: c_illegal = 1'b1;
    endcase
  end

  // Load-use hazard: only registered state feeds this, never the if_* inputs
  assign load_pending = idex_q.valid & idex_q.mem_read & (idex_q.rd != 3'd0) & ifid_valid;
  assign stall = load_pending &
                 ((uses_rs1 & (idex_q.rd == f_rs1)) | (uses_rs2 & (idex_q.rd == f_rs2)));

  // Next ID/EX contents; a stall or an empty IF/ID slot yields an all-zero bubble
  always_comb begin
    idex_d = '0;
    if (ifid_valid && !stall) begin
      idex_d.valid     = 1'b1;
      idex_d.pc        = ifid_pc;
      idex_d.rs1_val   = rs1_val;
      idex_d.rs2_val   = rs2_val;
      idex_d.imm       = f_imm;
      idex_d.rd        = c_reg_write ? f_rd : 3'd0;
      idex_d.alu_op    = c_alu_op;
      idex_d.reg_write = c_reg_write;
      idex_d.mem_read  = c_mem_read;
      idex_d.mem_write = c_mem_write;
      idex_d.branch    = c_branch;
      idex_d.use_imm   = c_use_imm;
      idex_d.illegal   = c_illegal;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= '0;
      idex_q     <= '0;
    end else if (flush) begin
      ifid_valid <= 1'b0;
      idex_q     <= '0;
    end else begin
      idex_q <= idex_d;
      if (!stall) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= if_pc;
        ifid_instr <= if_instr;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_en && wb_addr != 3'd0) begin
      regs[wb_addr] <= wb_data;
    end
  end

  assign ex_valid     = idex_q.valid;
  assign ex_pc        = idex_q.pc;
  assign ex_rs1_val   = idex_q.rs1_val;
  assign ex_rs2_val   = idex_q.rs2_val;
  assign ex_imm       = idex_q.imm;
  assign ex_rd        = idex_q.rd;
  assign ex_alu_op    = idex_q.alu_op;
  assign ex_reg_write = idex_q.reg_write;
  assign ex_mem_read  = idex_q.mem_read;
  assign ex_mem_write = idex_q.mem_write;
  assign ex_branch    = idex_q.branch;
  assign ex_use_imm   = idex_q.use_imm;
  assign ex_illegal   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - self-checking bench for id_stage

module tb_id_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  if_pc;
  logic [15:0] if_instr;
  logic        flush;
  logic        wb_en;
  logic [2:0]  wb_addr;
  logic [7:0]  wb_data;
  logic        stall;
  logic        ex_valid;
  logic [7:0]  ex_pc;
  logic [7:0]  ex_rs1_val;
  logic [7:0]  ex_rs2_val;
  logic [7:0]  ex_imm;
  logic [2:0]  ex_rd;
  logic [2:0]  ex_alu_op;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic        ex_branch;
  logic        ex_use_imm;
  logic        ex_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_stage dut (
    .clk(clk), .reset(reset), .if_pc(if_pc), .if_instr(if_instr), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .stall(stall),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_val(ex_rs1_val), .ex_rs2_val(ex_rs2_val),
    .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_alu_op(ex_alu_op), .ex_reg_write(ex_reg_write),
    .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_branch(ex_branch),
    .ex_use_imm(ex_use_imm), .ex_illegal(ex_illegal)
  );

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic       valid;
    logic [7:0] pc, a, b, imm;
    logic [2:0] rd, alu;
    logic       rw, mr, mw, br, ui, ill;
    logic       ua, ub;
  } exp_t;

  logic        m_if_valid;
  logic [7:0]  m_if_pc;
  logic [15:0] m_if_instr;
  exp_t        m_ex;
  logic [7:0]  m_rf [8];

  function automatic logic [2:0] second_reg(input logic [15:0] ins);
    int op = int'(ins[15:12]);
    return (op == 7 || op == 8) ? ins[11:9] : ins[5:3];
  endfunction

  function automatic logic reads_reg(input logic [15:0] ins, input logic [2:0] r);
    int op = int'(ins[15:12]);
    logic hit1 = (op >= 1 && op <= 8) && ins[8:6] == r;
    logic hit2 = ((op >= 1 && op <= 4) || op == 7 || op == 8) && second_reg(ins) == r;
    return hit1 || hit2;
  endfunction

  function automatic logic [7:0] reg_value(input logic [2:0] r);
    if (r == 3'd0) return 8'd0;
    if (wb_en && wb_addr == r) return wb_data;
    return m_rf[r];
  endfunction

  function automatic logic model_stall();
    return m_ex.valid && m_ex.mr && m_ex.rd != 3'd0 && m_if_valid && reads_reg(m_if_instr, m_ex.rd);
  endfunction

  function automatic exp_t model_decode(input logic [15:0] ins, input logic [7:0] pc);
    exp_t e = '0;
    int op = int'(ins[15:12]);
    e.valid = 1'b1;
    e.pc    = pc;
    e.imm   = 8'($signed(ins[5:0]));
    e.ill   = op > 8;
    e.rw    = (op >= 1 && op <= 6);
    e.mr    = op == 6;
    e.mw    = op == 7;
    e.br    = op == 8;
    e.ui    = (op >= 5 && op <= 7);
    e.alu   = (op >= 1 && op <= 4) ? 3'(op - 1) : (op == 8 ? 3'd1 : 3'd0);
    e.rd    = e.rw ? ins[11:9] : 3'd0;
    e.ua    = (op >= 1 && op <= 8);
    e.ub    = (op >= 1 && op <= 4) || op == 7 || op == 8;
    e.a     = reg_value(ins[8:6]);
    e.b     = reg_value(second_reg(ins));
    return e;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_if_valid <= 1'b0;
      m_if_pc    <= '0;
      m_if_instr <= '0;
      m_ex       <= '0;
      for (int i = 0; i < 8; i++) m_rf[i] <= '0;
    end else begin
      if (flush) begin
        m_if_valid <= 1'b0;
        m_ex       <= '0;
      end else if (model_stall()) begin
        m_ex <= '0;
      end else begin
        m_if_valid <= 1'b1;
        m_if_pc    <= if_pc;
        m_if_instr <= if_instr;
        m_ex       <= m_if_valid ? model_decode(m_if_instr, m_if_pc) : '0;
      end
      if (wb_en && wb_addr != 3'd0) m_rf[wb_addr] <= wb_data;
    end
  end

  // Compare process: checks every cycle outside reset
  always @(negedge clk) begin
    if (!reset) begin
      chk("m_stall", stall, model_stall());
      chk("m_valid", ex_valid, m_ex.valid);
      chk("m_reg_write", ex_reg_write, m_ex.rw);
      chk("m_mem_read", ex_mem_read, m_ex.mr);
      chk("m_mem_write", ex_mem_write, m_ex.mw);
      chk("m_branch", ex_branch, m_ex.br);
      chk("m_use_imm", ex_use_imm, m_ex.ui);
      chk("m_illegal", ex_illegal, m_ex.ill);
      chk("m_rd", ex_rd, m_ex.rd);
      if (m_ex.valid) begin
        chk("m_pc", ex_pc, m_ex.pc);
        chk("m_imm", ex_imm, m_ex.imm);
        chk("m_alu_op", ex_alu_op, m_ex.alu);
        if (m_ex.ua) chk("m_rs1_val", ex_rs1_val, m_ex.a);
        if (m_ex.ub) chk("m_rs2_val", ex_rs2_val, m_ex.b);
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step(input logic [7:0] pc, input logic [15:0] ins, input logic fl = 1'b0,
                      input logic we = 1'b0, input logic [2:0] wa = 3'd0, input logic [7:0] wd = 8'd0);
    @(negedge clk);
    if_pc    = pc;
    if_instr = ins;
    flush    = fl;
    wb_en    = we;
    wb_addr  = wa;
    wb_data  = wd;
    @(posedge clk);
    #2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; if_pc = '0; if_instr = '0; flush = 1'b0;
    wb_en = 1'b0; wb_addr = '0; wb_data = '0;
    repeat (2) @(negedge clk);
    chk("rst_stall", stall, 1'b0);
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_pc", ex_pc, 8'h00);
    chk("rst_reg_write", ex_reg_write, 1'b0);
    chk("rst_illegal", ex_illegal, 1'b0);
    reset = 1'b0;

    // ADD r5 = r1 + r2 at PC 3, two edges to execute
    step(8'd3, 16'h1A50);
    step(8'd4, 16'h0000);
    chk("add_valid", ex_valid, 1'b1);
    chk("add_pc", ex_pc, 8'd3);
    chk("add_rd", ex_rd, 3'd5);
    chk("add_alu", ex_alu_op, 3'd0);
    chk("add_rw", ex_reg_write, 1'b1);

    // r1 written early, r2 written in the decode cycle (bypass)
    step(8'd5, 16'h1650, 1'b0, 1'b1, 3'd1, 8'h11);
    step(8'd6, 16'h0000, 1'b0, 1'b1, 3'd2, 8'h22);
    chk("byp_rs1", ex_rs1_val, 8'h11);
    chk("byp_rs2", ex_rs2_val, 8'h22);
    chk("byp_rd", ex_rd, 3'd3);

    // ADDI imm6 = 0x3F, then illegal opcode 0xC
    step(8'd7, 16'h523F);
    step(8'd8, 16'hC000);
    chk("addi_imm", ex_imm, 8'hFF);
    chk("addi_ui", ex_use_imm, 1'b1);
    chk("addi_rd", ex_rd, 3'd1);
    step(8'd9, 16'h0000);
    chk("ill_flag", ex_illegal, 1'b1);
    chk("ill_valid", ex_valid, 1'b1);
    chk("ill_rw", ex_reg_write, 1'b0);
    chk("ill_rd", ex_rd, 3'd0);

    // LD r4,0(r1) then ADD r6,r4,r2: one bubble
    step(8'd10, 16'h6840);
    step(8'd11, 16'h1D10);
    chk("lu_stall", stall, 1'b1);
    chk("lu_ld_mr", ex_mem_read, 1'b1);
    step(8'd11, 16'h1D10);
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_stall_done", stall, 1'b0);
    step(8'd12, 16'h0000);
    chk("lu_add_valid", ex_valid, 1'b1);
    chk("lu_add_pc", ex_pc, 8'd11);
    chk("lu_add_rd", ex_rd, 3'd6);

    // LD r0 followed by a use of r0 never stalls
    step(8'd13, 16'h6040);
    step(8'd14, 16'h1A00);
    chk("r0_stall", stall, 1'b0);

    // ST and BEQ through the pipe
    step(8'h40, 16'h7650);
    step(8'h41, 16'h8A7E);
    chk("st_mw", ex_mem_write, 1'b1);
    chk("st_rd", ex_rd, 3'd0);
    step(8'd16, 16'h1650);
    chk("beq_br", ex_branch, 1'b1);
    chk("beq_alu", ex_alu_op, 3'd1);
    chk("beq_imm", ex_imm, 8'hFE);

    // Flush with both registers holding valid instructions
    step(8'd17, 16'h523F);
    chk("fl_pre_pc", ex_pc, 8'd16);
    step(8'd18, 16'h1A50, 1'b1);
    chk("fl_valid", ex_valid, 1'b0);
    step(8'd19, 16'h1650);
    chk("fl_empty", ex_valid, 1'b0);
    step(8'd20, 16'h0000);
    chk("fl_next_valid", ex_valid, 1'b1);
    chk("fl_next_pc", ex_pc, 8'd19);

    // Flush during a stall discards the stalled ADD
    step(8'd21, 16'h6840);
    step(8'd22, 16'h1D10);
    chk("fs_stall", stall, 1'b1);
    step(8'd22, 16'h1D10, 1'b1);
    chk("fs_stall_clr", stall, 1'b0);
    chk("fs_valid", ex_valid, 1'b0);
    step(8'd23, 16'h0000);
    chk("fs_dropped", ex_valid, 1'b0);
    step(8'd24, 16'h0000);
    chk("fs_next_pc", ex_pc, 8'd23);

    // Reset asserted mid-stall clears stall without a clock edge
    step(8'd25, 16'h6840);
    step(8'd26, 16'h1D10);
    chk("rs_stall", stall, 1'b1);
    #1 reset = 1'b1;
    #1;
    chk("rs_stall_clr", stall, 1'b0);
    chk("rs_valid_clr", ex_valid, 1'b0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Register file cleared by reset
    step(8'd30, 16'h1650);
    step(8'd31, 16'h0000);
    chk("rf_rst_pc", ex_pc, 8'd30);
    chk("rf_rst_rs1", ex_rs1_val, 8'h00);
    chk("rf_rst_rs2", ex_rs2_val, 8'h00);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
